// File: rtl/coin_intake.sv
// coin_intake: synchronises and debounces the four raw coin switches and
// emits one strobe plus an encoded coin value for each physical insertion.
// A multi-hot pattern that settles raises a one-cycle error pulse instead.
// A running tally of accepted coins saturates at all-ones.
module coin_intake #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int COUNT_W         = 8
) (
    input  logic               CLK50M,
    input  logic               reset,
    input  logic [3:0]         sw,
    output logic               coin_strobe,
    output logic [1:0]         coin_code,
    output logic               coin_err,
    output logic               busy,
    output logic [COUNT_W-1:0] coin_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        EVAL,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [3:0]         s1;
    logic [3:0]         s2;
    logic [3:0]         pat;
    logic [3:0]         pat_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               pat_one_hot;
    logic [1:0]         pat_code;
    logic               strobe_next;
    logic               err_next;
    logic [1:0]         code_next;
    logic [COUNT_W-1:0] count_next;

    // Two-flop synchroniser per switch bit; only s2 is used downstream.
    always_ff @(posedge CLK50M or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // State, debounce counter and latched pattern; reset enters HOLD so a
    // switch held through reset release is never taken as a coin.
    always_ff @(posedge CLK50M or posedge reset) begin
        if (reset) begin
            state <= HOLD;
            cnt   <= '0;
            pat   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pat   <= pat_next;
        end
    end

    // Next-state logic: any change while settling restarts the window.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pat_next   = pat;
        unique case (state)
            IDLE: begin
                if (s2 != 4'd0) begin
                    pat_next   = s2;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (s2 == 4'd0) begin
                    state_next = IDLE;
                end else if (s2 != pat) begin
                    pat_next = s2;
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = EVAL;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            EVAL: begin
                cnt_next   = '0;
                state_next = HOLD;
            end
            HOLD: begin
                if (s2 != 4'd0) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = HOLD;
                cnt_next   = '0;
            end
        endcase
    end

    // Qualify the latched pattern and encode its single set bit.
    always_comb begin
        pat_one_hot = (pat != 4'd0) && ((pat & (pat - 4'd1)) == 4'd0);
        pat_code    = 2'd0;
        unique case (pat)
            4'b0010: pat_code = 2'd1;
            4'b0100: pat_code = 2'd2;
            4'b1000: pat_code = 2'd3;
            default: pat_code = 2'd0;
        endcase
    end

    // Output decode: strobe or error only while evaluating; the code and
    // tally change only on an accepted coin, the tally sticking at all-ones.
    always_comb begin
        strobe_next = 1'b0;
        err_next    = 1'b0;
        code_next   = coin_code;
        count_next  = coin_count;
        if (state == EVAL) begin
            if (pat_one_hot) begin
                strobe_next = 1'b1;
                code_next   = pat_code;
                if (coin_count != {COUNT_W{1'b1}}) begin
                    count_next = coin_count + 1'b1;
                end
            end else begin
                err_next = 1'b1;
            end
        end
    end

    // Register the outputs so downstream logic sees clean single-cycle pulses.
    always_ff @(posedge CLK50M or posedge reset) begin
        if (reset) begin
            coin_strobe <= 1'b0;
            coin_err    <= 1'b0;
            coin_code   <= 2'd0;
            coin_count  <= '0;
        end else begin
            coin_strobe <= strobe_next;
            coin_err    <= err_next;
            coin_code   <= code_next;
            coin_count  <= count_next;
        end
    end

    assign busy = (state != IDLE);

endmodule
